seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; next generation of the fixed 1011 Mealy detector.
- Pattern width is a parameter; the pattern value is runtime-loadable; overlap/non-overlap is selected at runtime.
- Input bits are qualified by a valid strobe; the block keeps a saturating match counter.
- Sits on serial data paths as a frame/sync-word detector feeding control FSMs.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..32).
- PATTERN, 4'b1011, pattern value after reset, PAT_W bits.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only when high.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- pat_load  in  1  load pat_in into pattern register and flush history.
- pat_in  in  PAT_W  new pattern value.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  registered one-cycle detect pulse.
- match_cnt  out  CNT_W  saturating count of detections.

Behaviour:
- Reset (rst=0, asynchronous assert):
  - pattern register = PATTERN; history = 0; fill = 0.
  - match = 0; match_cnt = 0.
  - All resets take effect immediately, regardless of clock.
- Internal state:
  - hist[PAT_W-1:0]: last accepted bits, newest in LSB.
  - fill: count of bits accepted since last flush, saturating at PAT_W.
- Per rising edge, evaluated in priority order:
  1. pat_load=1:
     - pattern <= pat_in; hist <= 0; fill <= 0; match <= 0.
     - din is ignored even if din_valid=1.
  2. Else if din_valid=1:
     - cand = {hist[PAT_W-2:0], din}; hist <= cand.
     - hit = (cand == pattern) && (fill >= PAT_W-1).
     - On hit: match <= 1; fill <= overlap ? min(fill+1, PAT_W) : 0.
     - No hit: match <= 0; fill <= min(fill+1, PAT_W).
  3. Else (din_valid=0): match <= 0; hist and fill hold.
- Latency and pulse shape:
  - match goes high for exactly one cycle, after the edge at which the final pattern bit was sampled (registered Mealy).
  - Back-to-back hits in overlap mode give consecutive high cycles.
- Fill guard: no detection until PAT_W bits have been accepted since reset or flush. Reset zeros in hist can never produce a false match, including for an all-zero pattern.
- Non-overlap: after a hit, the next hit needs PAT_W fresh bits. Changing overlap mid-stream affects only the fill update at the next hit.
- match_cnt:
  - cnt_clr=1 forces 0; this takes priority over a simultaneous hit, so that hit is not counted.
  - Otherwise a hit increments the count, saturating at 2^CNT_W-1 (no wrap).
- pat_load does not clear match_cnt.
- No combinational path from inputs to outputs.

Test Plan:
- Pattern 1011, overlap=0, bits 1,0,1,1,0,1,1 all valid -> one match pulse after bit 4; no pulse after bit 7; match_cnt=1.
- Same stream, overlap=1 -> pulses after bit 4 and bit 7; match_cnt=2.
- pat_load with pat_in=4'b0000, then zeros -> no pulse on zeros 1-3, pulse on zero 4. With overlap=1, a pulse on every further zero.
- Pattern 1011 with din_valid low for 3 cycles between each bit -> single pulse, one cycle after the 4th valid bit; no pulses in gap cycles.
- CNT_W=2, overlap=1, pattern 0000, 10 zeros -> match_cnt saturates at 3. Then cnt_clr coinciding with a hit -> match_cnt=0 and match=1.
- Reset asserted mid-pattern after 1,0,1 -> match=0, match_cnt=0 immediately. After release, bit 1 alone gives no match; a full 1011 is required.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector: runtime-loadable PAT_W-bit pattern, overlap select,
// valid-qualified input, registered one-cycle match pulse and saturating match counter.
module seq_detect_param #(
   parameter int              PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int              CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int               FILL_W   = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
   localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic [PAT_W-1:0]  pattern_r;
   logic [PAT_W-1:0]  hist_r;
   logic [FILL_W-1:0] fill_r;
   logic              match_r;
   logic [CNT_W-1:0]  cnt_r;

   logic [PAT_W-1:0]  cand_s;
   logic [FILL_W-1:0] fill_inc_s;
   logic              hit_s;

   // Candidate window, saturating fill increment and fill-guarded hit decision
   always_comb begin
      cand_s     = {hist_r[PAT_W-2:0], din};
      fill_inc_s = fill_r;
      hit_s      = 1'b0;
      if (fill_r != FILL_MAX) begin
         fill_inc_s = fill_r + FILL_ONE;
      end else begin
         fill_inc_s = fill_r;
      end
      // fill guard keeps reset/flush zeros in hist from ever matching
      if (!pat_load && din_valid && (cand_s == pattern_r) && (fill_r >= FILL_ARM)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
   end

   // Pattern register, bit history, fill count and registered match pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern_r <= PATTERN;
         hist_r    <= '0;
         fill_r    <= '0;
         match_r   <= 1'b0;
      end else if (pat_load) begin
         pattern_r <= pat_in;
         hist_r    <= '0;
         fill_r    <= '0;
         match_r   <= 1'b0;
      end else if (din_valid) begin
         hist_r  <= cand_s;
         match_r <= hit_s;
         if (hit_s && !overlap) begin
            fill_r <= '0;
         end else begin
            fill_r <= fill_inc_s;
         end
      end else begin
         match_r <= 1'b0;
      end
   end

   // Saturating match counter; a clear wins over a coincident hit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= '0;
      end else if (cnt_clr) begin
         cnt_r <= '0;
      end else if (hit_s && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign match     = match_r;
   assign match_cnt = cnt_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a queue-based pattern model checked every
// cycle, plus literal expectations for the pulse trains and counter values.
module tb_seq_detect_param;

   localparam int PAT_W = 4;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             din;
   logic             din_valid;
   logic             overlap;
   logic             pat_load;
   logic [PAT_W-1:0] pat_in;
   logic             cnt_clr;
   logic             match;
   logic [CNT_W-1:0] match_cnt;

   seq_detect_param #(.PAT_W(PAT_W), .PATTERN(4'b1011), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .match(match), .match_cnt(match_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // model state: accepted bits since last flush / non-overlap restart, oldest first
   bit               q[$];
   logic [PAT_W-1:0] m_pat;
   bit               m_match;
   int               m_cnt;
   bit               exp_match;
   int               exp_cnt;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pat = 4'b1011;
      m_match = 1'b0;
      m_cnt = 0;
      exp_match = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic model_step(input bit ld, input logic [PAT_W-1:0] pin, input bit d,
                             input bit v, input bit ov, input bit clr);
      bit hit;
      hit = 1'b0;
      if (ld) begin
         m_pat = pin;
         q.delete();
      end else if (v) begin
         q.push_back(d);
         if (q.size() > PAT_W) void'(q.pop_front());
         if (q.size() == PAT_W) begin
            hit = 1'b1;
            for (int i = 0; i < PAT_W; i++)
               if (q[i] != m_pat[PAT_W-1-i]) hit = 1'b0;
         end
         if (hit && !ov) q.delete();
      end
      m_match = hit;
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < CMAX) m_cnt++;
   endtask

   // one clock: drive inputs, advance model, publish expectation just after the edge
   task automatic step(input bit ld, input logic [PAT_W-1:0] pin, input bit d, input bit v,
                       input bit ov, input bit clr, output bit mo);
      pat_load = ld; pat_in = pin; din = d; din_valid = v; overlap = ov; cnt_clr = clr;
      model_step(ld, pin, d, v, ov, clr);
      @(posedge clk);
      #1;
      exp_match = m_match;
      exp_cnt = m_cnt;
      mo = match;
   endtask

   task automatic send(input logic [15:0] bits, input int n, input bit ov, output logic [15:0] obs);
      bit mo;
      obs = '0;
      for (int i = n - 1; i >= 0; i--) begin
         step(1'b0, 4'b0000, bits[i], 1'b1, ov, 1'b0, mo);
         obs = {obs[14:0], mo};
      end
   endtask

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_match", {31'd0, match}, {31'd0, exp_match});
         chk("model_cnt", {30'd0, match_cnt}, exp_cnt);
      end
   end

   initial begin
      logic [15:0] obs;
      bit mo;
      rst = 1'b0; din = 1'b0; din_valid = 1'b0; overlap = 1'b0;
      pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
      model_reset();
      #3;
      chk("reset_match", {31'd0, match}, 32'd0);
      chk("reset_cnt", {30'd0, match_cnt}, 32'd0);
      #9 rst = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // non-overlap 1011 on 1011011: single pulse after bit 4
      send(16'b1011011, 7, 1'b0, obs);
      chk("nonovl_pulses", {25'd0, obs[6:0]}, 32'b0001000);
      chk("nonovl_cnt", {30'd0, match_cnt}, 32'd1);

      // overlap: pulses after bits 4 and 7
      step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b1, mo);
      send(16'b1011011, 7, 1'b1, obs);
      chk("ovl_pulses", {25'd0, obs[6:0]}, 32'b0001001);
      chk("ovl_cnt", {30'd0, match_cnt}, 32'd2);

      // all-zero pattern, non-overlap: pulses every 4 fresh zeros
      step(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, mo);
      send(16'b0, 8, 1'b0, obs);
      chk("zero_nonovl", {24'd0, obs[7:0]}, 32'b00010001);

      // all-zero pattern, overlap: first at zero 4 then every zero; counter saturates
      step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, mo);
      send(16'b0, 10, 1'b1, obs);
      chk("zero_ovl", {22'd0, obs[9:0]}, 32'b0001111111);
      chk("cnt_sat", {30'd0, match_cnt}, 32'd3);

      // clear coinciding with a hit: pulse still fires, count goes to 0
      step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, mo);
      chk("clr_hit_match", {31'd0, mo}, 32'd1);
      chk("clr_hit_cnt", {30'd0, match_cnt}, 32'd0);

      // gapped valid: din toggles during invalid cycles but must be ignored
      step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, mo);
      obs = '0;
      for (int b = 3; b >= 0; b--) begin
         logic [3:0] pat;
         pat = 4'b1011;
         step(1'b0, 4'b0000, pat[b], 1'b1, 1'b0, 1'b0, mo);
         obs = {obs[14:0], mo};
         for (int g = 0; g < 3; g++) begin
            step(1'b0, 4'b0000, ~pat[b], 1'b0, 1'b0, 1'b0, mo);
            obs = {obs[14:0], mo};
         end
      end
      chk("gap_pulses", {16'd0, obs}, 32'b0000000000001000);
      chk("gap_cnt", {30'd0, match_cnt}, 32'd1);

      // async reset mid-pattern with a non-default pattern loaded and count nonzero
      step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, mo);
      send(16'b101, 3, 1'b0, obs);
      rst = 1'b0;
      model_reset();
      #1;
      chk("midrst_match", {31'd0, match}, 32'd0);
      chk("midrst_cnt", {30'd0, match_cnt}, 32'd0);
      @(negedge clk);
      #1 rst = 1'b1;
      send(16'b1011, 4, 1'b0, obs);
      chk("post_rst_pulses", {28'd0, obs[3:0]}, 32'b0001);

      // async reset while match is high clears it without a clock edge
      step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, mo);
      send(16'b1011, 4, 1'b1, obs);
      chk("pre_rst_match", {31'd0, match}, 32'd1);
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("rst_kill_match", {31'd0, match}, 32'd0);
      chk("rst_kill_cnt", {30'd0, match_cnt}, 32'd0);
      @(negedge clk);
      #1 rst = 1'b1;
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, mo);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, mo);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
